// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - time-multiplexed 7-segment scan controller with frame-aligned commit
module seg_scan_ctrl #(
    parameter int NDIG  = 8,
    parameter int DIV   = 1000,
    parameter int GUARD = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              wr_en,
    input  logic [4*NDIG-1:0] wr_data,
    input  logic              blank_lz,
    output logic [3:0]        dec_b,
    input  logic [6:0]        dec_h,
    output logic [6:0]        seg,
    output logic [NDIG-1:0]   an,
    output logic              frame_done,
    output logic              busy
);

    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int CW = $clog2(DIV);

    localparam logic [IW-1:0] IDX_LAST  = IW'(NDIG - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_GLAST = CW'(GUARD - 1);
    localparam logic [6:0]    SEG_DARK  = 7'h7F;

    typedef enum logic [1:0] {
        S_OFF,
        S_GUARD,
        S_SHOW
    } state_t;

    state_t            state;
    logic [4*NDIG-1:0] pend;
    logic [4*NDIG-1:0] disp;
    logic              pend_v;
    logic [IW-1:0]     idx;
    logic [CW-1:0]     cnt;

    logic              nz_above;
    logic              blank;
    logic              commit_pt;
    logic [NDIG-1:0]   an_lit;
    logic [6:0]        seg_lit;

    always_comb begin
        dec_b    = 4'h0;
        nz_above = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (idx == IW'(i))
                dec_b = disp[4*i +: 4];
            // Any nonzero nibble at or above the current digit disables leading-zero blanking.
            if (IW'(i) >= idx && disp[4*i +: 4] != 4'h0)
                nz_above = 1'b1;
        end
    end

    assign blank     = (dec_b > 4'd9) || (blank_lz && idx != '0 && !nz_above);
    assign seg_lit   = blank ? SEG_DARK : dec_h;
    assign an_lit    = ~(NDIG'(1) << idx);
    assign commit_pt = en && state == S_SHOW && idx == IDX_LAST && cnt == CNT_LAST;
    assign busy      = pend_v;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_OFF;
            pend       <= '0;
            pend_v     <= 1'b0;
            disp       <= '0;
            idx        <= '0;
            cnt        <= '0;
            an         <= '1;
            seg        <= SEG_DARK;
            frame_done <= 1'b0;
        end else begin
            frame_done <= commit_pt;

            // A write coinciding with the commit point bypasses pend and lands directly.
            if (commit_pt) begin
                if (wr_en) begin
                    disp <= wr_data;
                    pend <= wr_data;
                end else if (pend_v) begin
                    disp <= pend;
                end
                pend_v <= 1'b0;
            end else if (wr_en) begin
                pend   <= wr_data;
                pend_v <= 1'b1;
            end

            if (!en) begin
                state <= S_OFF;
                idx   <= '0;
                cnt   <= '0;
                an    <= '1;
                seg   <= SEG_DARK;
            end else begin
                case (state)
                    S_OFF: begin
                        state <= S_GUARD;
                        cnt   <= '0;
                        an    <= '1;
                        seg   <= SEG_DARK;
                    end
                    S_GUARD: begin
                        cnt <= cnt + CW'(1);
                        if (cnt == CNT_GLAST) begin
                            state <= S_SHOW;
                            an    <= an_lit;
                            seg   <= seg_lit;
                        end else begin
                            an  <= '1;
                            seg <= SEG_DARK;
                        end
                    end
                    S_SHOW: begin
                        if (cnt == CNT_LAST) begin
                            state <= S_GUARD;
                            cnt   <= '0;
                            idx   <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
                            an    <= '1;
                            seg   <= SEG_DARK;
                        end else begin
                            cnt <= cnt + CW'(1);
                            an  <= an_lit;
                            seg <= seg_lit;
                        end
                    end
                    default: begin
                        state <= S_OFF;
                        idx   <= '0;
                        cnt   <= '0;
                        an    <= '1;
                        seg   <= SEG_DARK;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - scoreboard bench for seg_scan_ctrl against a frame-position model
module tb_seg_scan_ctrl;

    localparam int N = 4;
    localparam int D = 4;
    localparam int G = 1;
    localparam int L = N * D;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          wr_en;
    logic [4*N-1:0] wr_data;
    logic          blank_lz;
    logic [3:0]    dec_b;
    logic [6:0]    dec_h;
    logic [6:0]    seg;
    logic [N-1:0]  an;
    logic          frame_done;
    logic          busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.NDIG(N), .DIV(D), .GUARD(G)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .blank_lz   (blank_lz),
        .dec_b      (dec_b),
        .dec_h      (dec_h),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done),
        .busy       (busy)
    );

    function automatic logic [6:0] seg_tab(input logic [3:0] b);
        logic [6:0] hi;
        case (b)
            4'h0: hi = 7'h3F; 4'h1: hi = 7'h06; 4'h2: hi = 7'h5B; 4'h3: hi = 7'h4F;
            4'h4: hi = 7'h66; 4'h5: hi = 7'h6D; 4'h6: hi = 7'h7D; 4'h7: hi = 7'h07;
            4'h8: hi = 7'h7F; 4'h9: hi = 7'h6F; 4'hA: hi = 7'h77; 4'hB: hi = 7'h7C;
            4'hC: hi = 7'h39; 4'hD: hi = 7'h5E; 4'hE: hi = 7'h79; default: hi = 7'h71;
        endcase
        return ~hi;
    endfunction

    assign dec_h = seg_tab(dec_b);

    typedef struct {
        logic [N-1:0] an;
        logic [6:0]   seg;
        logic         fd;
        logic         busy;
        logic [3:0]   db;
    } exp_t;

    exp_t expq[$];

    int            t = -1;
    logic [4*N-1:0] m_disp = '0;
    logic [4*N-1:0] m_pend = '0;
    bit            m_pv = 1'b0;

    // Reference: t is the position since the scan started; frame slot, digit and phase follow by arithmetic.
    always @(posedge clk) begin
        exp_t e;
        bit commit;
        int p, dg;
        logic [3:0] nib;
        commit = 1'b0;
        if (!rst_n) begin
            t = -1; m_disp = '0; m_pend = '0; m_pv = 1'b0;
        end else begin
            if (en && t >= 0 && (t % L) == L - 1) commit = 1'b1;
            if (commit) begin
                if (wr_en) begin m_disp = wr_data; m_pend = wr_data; end
                else if (m_pv) m_disp = m_pend;
                m_pv = 1'b0;
            end else if (wr_en) begin
                m_pend = wr_data; m_pv = 1'b1;
            end
            t = en ? t + 1 : -1;
        end
        e.an = '1; e.seg = 7'h7F; e.fd = commit; e.busy = m_pv; e.db = m_disp[3:0];
        if (t >= 0) begin
            p   = t % L;
            dg  = p / D;
            nib = 4'((m_disp >> (4 * dg)) & 16'hF);
            e.db = nib;
            if ((p % D) >= G) begin
                e.an = ~(N'(1) << dg);
                if (nib > 4'd9 || (blank_lz && dg > 0 && (m_disp >> (4 * dg)) == 0))
                    e.seg = 7'h7F;
                else
                    e.seg = seg_tab(nib);
            end
        end
        expq.push_back(e);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("an", 32'(an), 32'(e.an));
            chk("seg", 32'(seg), 32'(e.seg));
            chk("frame_done", 32'(frame_done), 32'(e.fd));
            chk("busy", 32'(busy), 32'(e.busy));
            chk("dec_b", 32'(dec_b), 32'(e.db));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [4*N-1:0] d);
        wr_en = 1'b1; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    function automatic logic [4*N-1:0] rand_bcd();
        logic [4*N-1:0] v;
        for (int i = 0; i < N; i++) v[4*i +: 4] = 4'($urandom_range(0, 11));
        if ($urandom_range(0, 3) == 0) v[4*N-1 -: 8] = '0;
        return v;
    endfunction

    initial begin
        int guard_cnt;
        rst_n = 1'b0; en = 1'b1; wr_en = 1'b1; wr_data = 16'h4321; blank_lz = 1'b0;
        step(3);
        rst_n = 1'b1; wr_en = 1'b0; en = 1'b0;
        step(2);

        wr(16'h1234);
        en = 1'b1;
        step(40);
        wr(16'h5678);
        step(40);

        blank_lz = 1'b1;
        wr(16'h0070);
        step(40);
        wr(16'h0000);
        step(40);
        blank_lz = 1'b0;
        wr(16'h12A4);
        step(40);
        blank_lz = 1'b1;
        step(20);

        guard_cnt = 0;
        while (an !== 4'b1011 && guard_cnt < 100) begin
            @(negedge clk);
            guard_cnt++;
        end
        checks++;
        if (guard_cnt >= 100) begin
            errors++;
            $display("FAIL wait_digit2: got an=%b expected 1011 within 100 cycles", an);
        end
        en = 1'b0;
        wr(16'h9087);
        step(3);
        en = 1'b1;
        step(40);

        for (int c = 0; c < 1500; c++) begin
            wr_en    = ($urandom_range(0, 9) == 0);
            wr_data  = rand_bcd();
            if ($urandom_range(0, 49) == 0) blank_lz = ~blank_lz;
            if ($urandom_range(0, 59) == 0) en = 1'b0;
            else if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
            rst_n = ($urandom_range(0, 299) != 0);
            @(negedge clk);
        end
        wr_en = 1'b0; rst_n = 1'b1; en = 1'b1;
        step(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for the board's multi-digit 7-segment display. It owns a single shared BCD-to-7-segment decoder and feeds it one digit at a time. It drives the common digit-enable lines and latches the decoded pattern onto the shared segment bus. Sits between the CPU-side display register write port and the board pins; new values are committed only at frame boundaries so a frame never shows a mix of old and new digits.

## Interface
- NDIG, 8, number of digits scanned (2..8)
- DIV, 1000, clock cycles each digit is held (dwell); must satisfy DIV > GUARD + 1
- GUARD, 2, dead cycles at the start of each dwell with all digits off (anti-ghosting)

- clk  in  1  system clock, all logic rising-edge
- rst_n  in  1  synchronous active-low reset
- en  in  1  scan enable; 0 = display dark, scan frozen at reset position
- wr_en  in  1  one-cycle write strobe for wr_data
- wr_data  in  4*NDIG  packed BCD, nibble i = digit i (digit 0 least significant)
- blank_lz  in  1  leading-zero blanking enable
- dec_b  out  4  BCD code to shared decoder (combinational)
- dec_h  in  7  decoder result for dec_b, active-low segments
- seg  out  7  segment bus to pins, active-low, registered
- an  out  NDIG  digit enables, active-low, one-hot-low or all ones, registered
- frame_done  out  1  one-cycle pulse after the last digit's dwell completes
- busy  out  1  high while a written value is pending commit

## Operation
- Registers: pend[4*NDIG], pend_v, disp[4*NDIG], idx (0..NDIG-1), cnt (0..DIV-1), state.
- Write: wr_en=1 loads pend<=wr_data, pend_v<=1. A later write before the commit overwrites pend, last write wins. busy = pend_v.
- Commit: on the cycle where idx=NDIG-1 and cnt=DIV-1 with en=1, disp<=pend if pend_v, then pend_v<=0. If wr_en occurs in the same cycle, the new wr_data is committed directly, and pend_v ends 0.
- FSM states:
  - OFF: entered on reset or en=0. Outputs idx=0, cnt=0, an all ones, seg=7'h7F. OFF -> GUARD when en=1.
  - GUARD: cnt counts 0..GUARD-1, an all ones. At cnt=GUARD-1 -> SHOW.
  - SHOW: cnt counts GUARD..DIV-1, an[idx]=0. At cnt=DIV-1: cnt<=0, idx<=idx+1 wrapping NDIG-1 -> 0, -> GUARD.
  - en=0 in any state -> OFF on the next edge.
  - Writes and commits are unaffected by state, except that commit requires en=1.
- dec_b = disp nibble[idx].
- A digit is blank if its nibble > 9.
- A digit is also blank if blank_lz=1 and its nibble and all more-significant nibbles are 0. Digit 0 is never LZ-blanked.
- seg register: in SHOW (next state), seg <= blank ? 7'h7F : dec_h; otherwise 7'h7F.
- frame_done <= 1 for exactly the cycle after the commit point, 0 otherwise.

## Timing
- Reset values (rst_n=0 at an edge): seg=7'h7F, an=all ones, frame_done=0, busy=0, disp=0, pend=0, idx=0, cnt=0, state OFF.
- Reset mid-write or mid-frame discards pend and disp.
- seg and an are registered together and always change on the same edge, so no segment/enable skew.
- Per digit: GUARD cycles dark, then DIV-GUARD cycles lit. Frame period = NDIG*DIV cycles.
- Write-to-visible latency:
  - at least 1 cycle after the commit edge, plus the remainder of the current frame;
  - at most NDIG*DIV + GUARD + 1 cycles after wr_en.
- en rise to first lit digit: 1 (OFF->GUARD) + GUARD cycles. Digit 0 shows first.
- en fall: an all ones and seg=7'h7F one edge later.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with en=1 and wr_en=1 -> seg=7'h7F, an=all ones, busy=0, frame_done=0 throughout.
- Basic scan (NDIG=4, DIV=4, GUARD=1):
  - stimulus: wr_data=16'h1234, en=1;
  - after the first commit: an sequence per digit is 1111, then 1110 held 3 cycles, then next digit;
  - dec_b = 4,3,2,1 in digit order;
  - frame_done pulses every 16 cycles.
- Tear-free update: write 16'h5678 mid-frame -> digits keep 1234 until the frame_done pulse, busy=1 until the commit; the next frame shows 5678.
- Leading-zero blanking: wr_data=16'h0070, blank_lz=1 -> digits 3 and 2 show seg=7'h7F, digit 1 shows dec_h (7), digit 0 shows dec_h (0). wr_data=16'h0000 -> only digit 0 lit.
- Invalid BCD and dead time: nibble 4'hA on digit 1 -> seg=7'h7F during its dwell; during every GUARD cycle an is all ones regardless of data.
- Enable toggle: drop en mid-SHOW on digit 2 -> next edge dark, idx=0. Re-raise en -> GUARD then digit 0. A write made while en=0 stays pending (busy=1) until the first frame completes.
